// File: rtl/stage6_mc8_serializer.sv
// Stage-6 serializer: accepts a group of three MC8 lane fields and emits the
// non-default ones one per cycle, lowest lane first, on a valid/ready stream.
module stage6_mc8_serializer #(
    parameter int                 FIELD_W       = 64,
    parameter logic [FIELD_W-1:0] DEFAULT_INFOR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               message_en,
    input  logic [FIELD_W-1:0] MC8_1,
    input  logic [FIELD_W-1:0] MC8_2,
    input  logic [FIELD_W-1:0] MC8_3,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] out_MC8,
    output logic [1:0]         out_lane,
    output logic               out_last,
    output logic [15:0]        grp_count,
    output logic [15:0]        empty_count
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [2:0]         r_pend;
    logic [2:0]         w_pendNext;
    logic [FIELD_W-1:0] r_hold1;
    logic [FIELD_W-1:0] r_hold2;
    logic [FIELD_W-1:0] r_hold3;
    logic [15:0]        r_grpCount;
    logic [15:0]        r_emptyCount;

    logic [2:0]         w_newPend;
    logic               w_accept;
    logic               w_transfer;
    logic [1:0]         w_lane;
    logic [2:0]         w_laneMask;
    logic [FIELD_W-1:0] w_data;
    logic               w_last;

    assign w_newPend = {MC8_3 != DEFAULT_INFOR, MC8_2 != DEFAULT_INFOR, MC8_1 != DEFAULT_INFOR};

    // Presentation is driven purely from registered state, so out_valid and
    // the payload never depend combinationally on out_ready.
    always_comb begin
        w_lane     = 2'd0;
        w_laneMask = 3'b000;
        w_data     = DEFAULT_INFOR;
        if (r_pend[0]) begin
            w_lane     = 2'd1;
            w_laneMask = 3'b001;
            w_data     = r_hold1;
        end else if (r_pend[1]) begin
            w_lane     = 2'd2;
            w_laneMask = 3'b010;
            w_data     = r_hold2;
        end else if (r_pend[2]) begin
            w_lane     = 2'd3;
            w_laneMask = 3'b100;
            w_data     = r_hold3;
        end
    end

    assign w_last     = (r_state == EMIT) && ((r_pend & ~w_laneMask) == 3'b000);
    assign out_valid  = (r_state == EMIT);
    assign out_MC8    = w_data;
    assign out_lane   = w_lane;
    assign out_last   = w_last;
    assign w_transfer = out_valid & out_ready;

    // Ready also rises on the final transfer so the next group lands with no bubble.
    assign in_ready = (r_state == IDLE) | (w_transfer & w_last);
    assign w_accept = message_en & in_ready;

    always_comb begin
        w_stateNext = r_state;
        w_pendNext  = r_pend;
        if (w_accept) begin
            w_pendNext  = w_newPend;
            w_stateNext = (w_newPend != 3'b000) ? EMIT : IDLE;
        end else if (w_transfer) begin
            w_pendNext = r_pend & ~w_laneMask;
            if (w_last) begin
                w_stateNext = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= 3'b000;
        end else begin
            r_state <= w_stateNext;
            r_pend  <= w_pendNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold1 <= DEFAULT_INFOR;
            r_hold2 <= DEFAULT_INFOR;
            r_hold3 <= DEFAULT_INFOR;
        end else if (w_accept) begin
            r_hold1 <= MC8_1;
            r_hold2 <= MC8_2;
            r_hold3 <= MC8_3;
        end
    end

    // Statistics counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grpCount   <= 16'd0;
            r_emptyCount <= 16'd0;
        end else if (w_accept) begin
            if (w_newPend != 3'b000) begin
                r_grpCount <= r_grpCount + 16'd1;
            end else begin
                r_emptyCount <= r_emptyCount + 16'd1;
            end
        end
    end

    assign grp_count   = r_grpCount;
    assign empty_count = r_emptyCount;

endmodule

// File: tb/tb_stage6_mc8_serializer.sv
// Directed testbench for stage6_mc8_serializer: per-cycle vector table plus
// hand-written reset-during-emission and counter-wrap sequences.
module tb_stage6_mc8_serializer;

    localparam int FW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          message_en;
    logic [FW-1:0] MC8_1;
    logic [FW-1:0] MC8_2;
    logic [FW-1:0] MC8_3;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_MC8;
    logic [1:0]    out_lane;
    logic          out_last;
    logic [15:0]   grp_count;
    logic [15:0]   empty_count;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic          en;
        logic [FW-1:0] mc1;
        logic [FW-1:0] mc2;
        logic [FW-1:0] mc3;
        logic          ordy;
        logic          expInReady;
        logic          expValid;
        logic [FW-1:0] expData;
        logic [1:0]    expLane;
        logic          expLast;
        logic [15:0]   expGrp;
        logic [15:0]   expEmpty;
    } vec_t;

    vec_t vecs[$];

    stage6_mc8_serializer #(
        .FIELD_W(FW),
        .DEFAULT_INFOR('0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .message_en(message_en),
        .MC8_1(MC8_1),
        .MC8_2(MC8_2),
        .MC8_3(MC8_3),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_MC8(out_MC8),
        .out_lane(out_lane),
        .out_last(out_last),
        .grp_count(grp_count),
        .empty_count(empty_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic en, input logic [FW-1:0] m1, input logic [FW-1:0] m2,
                                 input logic [FW-1:0] m3, input logic ordy);
        @(negedge clk);
        message_en = en;
        MC8_1      = m1;
        MC8_2      = m2;
        MC8_3      = m3;
        out_ready  = ordy;
        #1;
    endtask

    task automatic addVec(input logic en, input logic [FW-1:0] m1, input logic [FW-1:0] m2,
                          input logic [FW-1:0] m3, input logic ordy, input logic eRdy,
                          input logic eVal, input logic [FW-1:0] eData, input logic [1:0] eLane,
                          input logic eLast, input logic [15:0] eGrp, input logic [15:0] eEmpty);
        vec_t v;
        v.en = en; v.mc1 = m1; v.mc2 = m2; v.mc3 = m3; v.ordy = ordy;
        v.expInReady = eRdy; v.expValid = eVal; v.expData = eData;
        v.expLane = eLane; v.expLast = eLast; v.expGrp = eGrp; v.expEmpty = eEmpty;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n      = 1'b0;
        message_en = 1'b0;
        MC8_1      = '0;
        MC8_2      = '0;
        MC8_3      = '0;
        out_ready  = 1'b0;

        // en, mc1, mc2, mc3, ordy | inReady, valid, data, lane, last, grp, empty
        // Sparse group: lanes 1 and 3 back to back
        addVec(1, 64'hA1, 0, 64'hC3, 1,   1, 0, 0,      0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1,             0, 1, 64'hA1, 1, 0, 1, 0);
        addVec(0, 0, 0, 0, 1,             1, 1, 64'hC3, 3, 1, 1, 0);
        addVec(0, 0, 0, 0, 1,             1, 0, 0,      0, 0, 1, 0);
        // All-default group is dropped
        addVec(1, 0, 0, 0, 1,             1, 0, 0,      0, 0, 1, 0);
        addVec(0, 0, 0, 0, 1,             1, 0, 0,      0, 0, 1, 1);
        // Backpressure for five cycles, then drain
        addVec(1, 1, 2, 3, 0,             1, 0, 0,      0, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            addVec(0, 0, 0, 0, 0,         0, 1, 1,      1, 0, 2, 1);
        end
        addVec(0, 0, 0, 0, 1,             0, 1, 1,      1, 0, 2, 1);
        addVec(0, 0, 0, 0, 1,             0, 1, 2,      2, 0, 2, 1);
        addVec(0, 0, 0, 0, 1,             1, 1, 3,      3, 1, 2, 1);
        addVec(0, 0, 0, 0, 1,             1, 0, 0,      0, 0, 2, 1);
        // Back-to-back groups with no gap
        addVec(1, 5, 0, 0, 1,             1, 0, 0,      0, 0, 2, 1);
        addVec(1, 0, 0, 9, 1,             1, 1, 5,      1, 1, 3, 1);
        addVec(0, 0, 0, 0, 1,             1, 1, 9,      3, 1, 4, 1);
        addVec(0, 0, 0, 0, 1,             1, 0, 0,      0, 0, 4, 1);
        // Empty group accepted on the last transfer returns to idle
        addVec(1, 7, 0, 0, 1,             1, 0, 0,      0, 0, 4, 1);
        addVec(1, 0, 0, 0, 1,             1, 1, 7,      1, 1, 5, 1);
        addVec(0, 0, 0, 0, 1,             1, 0, 0,      0, 0, 5, 2);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetValid", {63'd0, out_valid}, 0);
        checkOutput("resetLast",  {63'd0, out_last}, 0);
        checkOutput("resetLane",  {62'd0, out_lane}, 0);
        checkOutput("resetData",  out_MC8, 0);
        checkOutput("resetGrp",   {48'd0, grp_count}, 0);
        checkOutput("resetEmpty", {48'd0, empty_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("resetInReady", {63'd0, in_ready}, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].mc1, vecs[i].mc2, vecs[i].mc3, vecs[i].ordy);
            checkOutput($sformatf("v%0d inReady", i), {63'd0, in_ready}, {63'd0, vecs[i].expInReady});
            checkOutput($sformatf("v%0d valid", i), {63'd0, out_valid}, {63'd0, vecs[i].expValid});
            if (vecs[i].expValid) begin
                checkOutput($sformatf("v%0d data", i), out_MC8, vecs[i].expData);
                checkOutput($sformatf("v%0d lane", i), {62'd0, out_lane}, {62'd0, vecs[i].expLane});
                checkOutput($sformatf("v%0d last", i), {63'd0, out_last}, {63'd0, vecs[i].expLast});
            end
            checkOutput($sformatf("v%0d grp", i), {48'd0, grp_count}, {48'd0, vecs[i].expGrp});
            checkOutput($sformatf("v%0d empty", i), {48'd0, empty_count}, {48'd0, vecs[i].expEmpty});
        end

        // Reset asserted while lane 2 of (1,2,3) is being presented
        applyStimulus(1, 1, 2, 3, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("midLane1", {62'd0, out_lane}, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("midLane2", {62'd0, out_lane}, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", {63'd0, out_valid}, 0);
        checkOutput("midRstLane",  {62'd0, out_lane}, 0);
        checkOutput("midRstLast",  {63'd0, out_last}, 0);
        checkOutput("midRstData",  out_MC8, 0);
        checkOutput("midRstGrp",   {48'd0, grp_count}, 0);
        checkOutput("midRstEmpty", {48'd0, empty_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput($sformatf("postRst%0d valid", k), {63'd0, out_valid}, 0);
            checkOutput($sformatf("postRst%0d inReady", k), {63'd0, in_ready}, 1);
        end

        // One single-lane group accepted per cycle until grp_count wraps
        applyStimulus(1, 5, 0, 0, 1);
        repeat (65535) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("wrapFFFF", {48'd0, grp_count}, 64'hFFFF);
        checkOutput("wrapInReady", {63'd0, in_ready}, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("wrapZero", {48'd0, grp_count}, 0);
        checkOutput("wrapEmpty", {48'd0, empty_count}, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
